// File: rtl/multi_alu_ctrl_unit.sv
// ALU control and execute unit: decodes ALUop/FUNC, runs single-cycle ops with a
// registered result, and runs iterative MULTU/DIVU into the HI/LO registers.
module multi_alu_ctrl_unit #(
   parameter int unsigned WIDTH  = 32,
   parameter bit          MUL_EN = 1'b1,
   parameter bit          DIV_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               ALUop,
   input  logic [5:0]               FUNC,
   input  logic [$clog2(WIDTH)-1:0] SHAMT,
   input  logic [WIDTH-1:0]         A,
   input  logic [WIDTH-1:0]         B,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         RESULT,
   output logic                     ZERO,
   output logic                     OVF,
   output logic                     busy,
   output logic [WIDTH-1:0]         HI,
   output logic [WIDTH-1:0]         LO
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e               state_q, state_d;
   // Shared iteration register: {HI, LO} for multiply, {remainder, quotient} for divide
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opd_q, opd_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 ovf_q, ovf_d;
   logic                 valid_q, valid_d;
   logic                 busy_q, busy_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic                 accept;
   logic [WIDTH-1:0]     sum, diff;
   logic                 add_ovf, sub_ovf;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_ovf;
   logic                 is_mul, is_div;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_trial;
   logic [2*WIDTH-1:0]   div_next;

   assign accept  = in_valid & ~busy_q;
   assign sum     = A + B;
   assign diff    = A - B;
   assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
   assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

   // Decode ALUop/FUNC into a single-cycle result or a multi-cycle start
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      is_mul  = 1'b0;
      is_div  = 1'b0;
      unique case (ALUop)
         2'b00: begin
            alu_res = sum;
            alu_ovf = add_ovf;
         end
         2'b01: begin
            alu_res = diff;
            alu_ovf = sub_ovf;
         end
         2'b11: alu_res = A | B;
         2'b10: begin
            case (FUNC)
               6'h20: begin
                  alu_res = sum;
                  alu_ovf = add_ovf;
               end
               6'h21: alu_res = sum;
               6'h22: begin
                  alu_res = diff;
                  alu_ovf = sub_ovf;
               end
               6'h23: alu_res = diff;
               6'h24: alu_res = A & B;
               6'h25: alu_res = A | B;
               6'h26: alu_res = A ^ B;
               6'h27: alu_res = ~(A | B);
               6'h2A: alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
               6'h2B: alu_res = {{(WIDTH-1){1'b0}}, A < B};
               6'h00: alu_res = B << SHAMT;
               6'h02: alu_res = B >> SHAMT;
               6'h03: alu_res = $signed(B) >>> SHAMT;
               6'h10: alu_res = hi_q;
               6'h12: alu_res = lo_q;
               6'h19: is_mul = MUL_EN;
               6'h1B: is_div = DIV_EN;
               default: ;
            endcase
         end
      endcase
   end

   // One iteration of shift-add multiply and restoring divide
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
      // A negative trial restores: the shifted remainder is kept and the quotient bit is 0
      div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   end

   // Next-state for the FSM, iteration datapath and registered outputs
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_mul) begin
                  state_d = StMul;
                  acc_d   = {{WIDTH{1'b0}}, B};
                  opd_d   = A;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
               end else if (is_div) begin
                  busy_d = 1'b1;
                  cnt_d  = '0;
                  opd_d  = B;
                  if (B == '0) begin
                     state_d = StDone;
                     acc_d   = {A, {WIDTH{1'b1}}};
                  end else begin
                     state_d = StDiv;
                     acc_d   = {{WIDTH{1'b0}}, A};
                  end
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  ovf_d    = alu_ovf;
                  valid_d  = 1'b1;
               end
            end
         end
         StMul: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end
         StDiv: begin
            acc_d = div_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end
         StDone: begin
            hi_d     = acc_q[2*WIDTH-1:WIDTH];
            lo_d     = acc_q[WIDTH-1:0];
            result_d = acc_q[WIDTH-1:0];
            zero_d   = (acc_q[WIDTH-1:0] == '0);
            ovf_d    = 1'b0;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = StIdle;
         end
      endcase
   end

   // State registers; reset aborts any op in flight without an output pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         opd_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign in_ready  = ~busy_q;
   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign RESULT    = result_q;
   assign ZERO      = zero_q;
   assign OVF       = ovf_q;
   assign HI        = hi_q;
   assign LO        = lo_q;

endmodule
